// File: rtl/buttons_pio_pkg.sv
// Shared constants and bus request type for the debounced button PIO.
package buttons_pio_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: synchroniser, stable-count debouncer and edge detect.
module pio_debounce_bit
  import buttons_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic deb,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb <= 1'b0;
        else          deb <= sync;
      end
    end else begin : g_count
      localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] cnt;

      // Any cycle where sync agrees with deb restarts the stability window.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (sync == deb) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          deb <= sync;
          cnt <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_d <= 1'b0;
    else          deb_d <= deb;
  end

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

endmodule

// File: rtl/buttons_pio_db.sv
// Avalon-MM button PIO: per-channel debounce, W1C edge capture, masked level IRQ.
module buttons_pio_db
  import buttons_pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  bus_req_t         req;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] sync, deb, rise, fall, ev, clr;
  logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_wdata;

  assign req  = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};
  assign wdat = req.wdata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .SYNC_STAGES    (SYNC_STAGES)
      ) u_bit (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[i]),
        .sync   (sync[i]),
        .deb    (deb[i]),
        .rise   (rise[i]),
        .fall   (fall[i])
      );
    end
  endgenerate

  assign ev  = (rise & rise_en) | (fall & fall_en);
  assign clr = (req.wr && req.addr == ADDR_EDGECAP) ? wdat : '0;

  // A new event in the same cycle as its W1C clear stays captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= '0;
      fall_en  <= '1;
    end else begin
      edge_cap <= (edge_cap & ~clr) | ev;
      if (req.wr) begin
        case (req.addr)
          ADDR_IRQMASK: irq_mask <= wdat;
          ADDR_RISE_EN: rise_en  <= wdat;
          ADDR_FALL_EN: fall_en  <= wdat;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = deb;
      ADDR_RAW:     rd_mux = sync;
      ADDR_IRQMASK: rd_mux = irq_mask;
      ADDR_EDGECAP: rd_mux = edge_cap;
      ADDR_RISE_EN: rd_mux = rise_en;
      ADDR_FALL_EN: rd_mux = fall_en;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= 32'(rd_mux);
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_buttons_pio_db.sv
// Randomised and directed bench for buttons_pio_db against a history-based model.
module tb_buttons_pio_db;

  localparam int W = 3;
  localparam int D = 4;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic [W-1:0]  in_port = '0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  buttons_pio_db #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in_port samples per edge; sync is the sample S edges back, and deb
  // flips once the last D sync values all disagree with it.
  logic [W-1:0] smp[$];
  logic [W-1:0] m_deb, m_deb_d, m_mask, m_cap, m_rise, m_fall;
  logic [31:0]  m_rd;

  function automatic logic [W-1:0] past(int k);
    int idx;
    idx = smp.size() - 1 - k;
    return (idx >= 0) ? smp[idx] : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_deb <= '0; m_deb_d <= '0; m_mask <= '0; m_cap <= '0;
      m_rise <= '0; m_fall <= '1; m_rd <= '0;
      smp.delete();
    end else begin : step
      logic [W-1:0] sy, ev, nd, wd, clr, lvl;
      bit wr_now, agree;
      smp.push_back(in_port);
      if (smp.size() > S + D + 2) void'(smp.pop_front());
      sy     = past(S);
      wr_now = chipselect && !write_n;
      wd     = writedata[W-1:0];
      case (address)
        3'd0: m_rd <= 32'(m_deb);
        3'd1: m_rd <= 32'(sy);
        3'd2: m_rd <= 32'(m_mask);
        3'd3: m_rd <= 32'(m_cap);
        3'd4: m_rd <= 32'(m_rise);
        3'd5: m_rd <= 32'(m_fall);
        default: m_rd <= '0;
      endcase
      ev = (m_deb & ~m_deb_d & m_rise) | (~m_deb & m_deb_d & m_fall);
      nd = m_deb;
      for (int b = 0; b < W; b++) begin
        agree = 1'b1;
        for (int k = 0; k < D; k++) begin
          lvl = past(S + k);
          if (lvl[b] == m_deb[b]) agree = 1'b0;
        end
        if (agree) nd[b] = ~m_deb[b];
      end
      clr = (wr_now && address == 3'd3) ? wd : '0;
      m_cap <= (m_cap & ~clr) | ev;
      if (wr_now && address == 3'd2) m_mask <= wd;
      if (wr_now && address == 3'd4) m_rise <= wd;
      if (wr_now && address == 3'd5) m_fall <= wd;
      m_deb_d <= m_deb;
      m_deb   <= nd;
    end
  end

  always @(posedge clk) begin
    #2;
    if (reset_n && chk_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end
  end

  task automatic wr(logic [2:0] a, logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] exp, string name);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  initial begin
    int hold;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    rd(3'd5, 32'h7, "rst_fall_en");
    rd(3'd0, 32'h0, "rst_data");
    rd(3'd2, 32'h0, "rst_irqmask");
    rd(3'd3, 32'h0, "rst_edgecap");
    rd(3'd4, 32'h0, "rst_rise_en");
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Falling edge with interrupt
    @(negedge clk); in_port = 3'b111;
    repeat (10) @(negedge clk);
    rd(3'd0, 32'h7, "data_high");
    rd(3'd3, 32'h0, "rise_not_captured");
    wr(3'd2, 32'h1);
    @(negedge clk); in_port[0] = 1'b0; address = 3'd0;
    repeat (6) @(negedge clk);
    check("data_before_latency", readdata, 32'h7);
    @(negedge clk);
    check("data_latency", readdata, 32'h6);
    check("irq_fall", {31'b0, irq}, 32'h1);
    rd(3'd3, 32'h1, "edgecap_fall");
    wr(3'd3, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Glitch rejection
    @(negedge clk); in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    repeat (12) @(negedge clk);
    rd(3'd0, 32'h6, "glitch_data");
    rd(3'd3, 32'h0, "glitch_edgecap");

    // Both-edge mode on bit 2
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h4);
    @(negedge clk); in_port[2] = 1'b0;
    repeat (10) @(negedge clk);
    rd(3'd3, 32'h4, "both_fall");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "both_cleared");
    @(negedge clk); in_port[2] = 1'b1;
    repeat (10) @(negedge clk);
    rd(3'd3, 32'h4, "both_rise");
    wr(3'd3, 32'h4);

    // Rise event lands on the same edge as a W1C of that bit
    wr(3'd4, 32'h5);
    wr(3'd3, 32'h7);
    @(negedge clk); in_port[0] = 1'b1;
    repeat (5) @(negedge clk);
    wr(3'd3, 32'h1);
    check("simul_irq", {31'b0, irq}, 32'h1);
    rd(3'd3, 32'h1, "simul_cap");
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h1, "w1c_zero");
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h0, "w1c_one");

    // Reset mid-debounce with inputs held low
    @(negedge clk); in_port = 3'b000;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    rd(3'd0, 32'h0, "post_rst_data");
    rd(3'd3, 32'h0, "post_rst_edgecap");
    rd(3'd2, 32'h0, "post_rst_irqmask");
    rd(3'd4, 32'h0, "post_rst_rise_en");
    rd(3'd5, 32'h7, "post_rst_fall_en");
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    // Random traffic, checked every cycle by the model
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'($urandom_range(0, 1));
        writedata  = $urandom;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
